// File: rtl/pipe_bus_sequencer.sv
// Memory-bus sequencer for the JAM-1 front end: arbitrates DMA, data and
// fetch, and drives the fetch flush and PC/RA flip flag into pipe_stage0.
module pipe_bus_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int DMA_MAX      = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       DataBusReq,
    input  logic       BranchTaken,
    input  logic       PcraFlipReq,
    input  logic       DmaReq,
    output logic       DmaAck,
    output logic       BusRequest,
    output logic       FetchSuppress,
    output logic       Flag5_PCRA_Flip,
    output logic [1:0] BusOwner
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMA_SYNC  = 2'd1,
        DMA_GRANT = 2'd2,
        DMA_REL   = 2'd3
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam logic [7:0] GRANT_LAST = 8'(DMA_MAX - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] grant_cnt;
    logic [3:0] flush_cnt;
    logic       flip;
    logic       ack;
    logic       grant_done;

    // The last grant cycle is the one whose count reaches DMA_MAX at this edge.
    assign grant_done = (grant_cnt >= GRANT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (DmaReq && !DataBusReq) begin
                    state_nxt = DMA_SYNC;
                end
            end
            DMA_SYNC: begin
                state_nxt = DMA_GRANT;
            end
            DMA_GRANT: begin
                if (!DmaReq || grant_done) begin
                    state_nxt = DMA_REL;
                end
            end
            // Always back to RUN, so a forced release leaves one fetch/data slot.
            DMA_REL: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        BusRequest = 1'b1;
        BusOwner   = 2'b11;
        case (state)
            RUN: begin
                BusRequest = DataBusReq;
                BusOwner   = DataBusReq ? 2'b01 : 2'b00;
            end
            DMA_GRANT: begin
                BusOwner = 2'b10;
            end
            default: begin
                BusOwner = 2'b11;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack       <= 1'b0;
            grant_cnt <= 8'd0;
        end else begin
            ack <= (state_nxt == DMA_GRANT);
            if (state != DMA_GRANT) begin
                grant_cnt <= 8'd0;
            end else if (grant_cnt != 8'hff) begin
                grant_cnt <= grant_cnt + 8'd1;
            end
        end
    end

    // Only RUN cycles without a data access consume a fetched byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= 4'd0;
        end else if (BranchTaken) begin
            flush_cnt <= FLUSH_LOAD;
        end else if (state == RUN && !DataBusReq && flush_cnt != 4'd0) begin
            flush_cnt <= flush_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flip <= 1'b0;
        end else if (PcraFlipReq) begin
            flip <= ~flip;
        end
    end

    assign DmaAck          = ack;
    assign FetchSuppress   = (flush_cnt != 4'd0);
    assign Flag5_PCRA_Flip = flip;

endmodule

// File: tb/tb_pipe_bus_sequencer.sv
// Directed bench for pipe_bus_sequencer: arbitration, flush, DMA
// handshake, forced release, PC/RA flip and mid-grant reset.
module tb_pipe_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       DataBusReq;
    logic       BranchTaken;
    logic       PcraFlipReq;
    logic       DmaReq;
    logic       DmaAck;
    logic       BusRequest;
    logic       FetchSuppress;
    logic       Flag5_PCRA_Flip;
    logic [1:0] BusOwner;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_bus_sequencer #(
        .FLUSH_CYCLES(2),
        .DMA_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .DataBusReq(DataBusReq),
        .BranchTaken(BranchTaken),
        .PcraFlipReq(PcraFlipReq),
        .DmaReq(DmaReq),
        .DmaAck(DmaAck),
        .BusRequest(BusRequest),
        .FetchSuppress(FetchSuppress),
        .Flag5_PCRA_Flip(Flag5_PCRA_Flip),
        .BusOwner(BusOwner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string tag, input logic breq,
                           input logic [1:0] own, input logic ack);
        #1;
        check({tag, ".breq"}, 8'(BusRequest), 8'(breq));
        check({tag, ".own"}, 8'(BusOwner), 8'(own));
        check({tag, ".ack"}, 8'(DmaAck), 8'(ack));
    endtask

    task automatic chk_fs(input string tag, input logic fs);
        #1;
        check(tag, 8'(FetchSuppress), 8'(fs));
    endtask

    initial begin
        rst = 1'b1;
        DataBusReq = 1'b0;
        BranchTaken = 1'b0;
        PcraFlipReq = 1'b0;
        DmaReq = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset state, held while idle
        for (int i = 0; i < 2; i++) begin
            chk_bus("rst", 1'b0, 2'b00, 1'b0);
            chk_fs("rst.fs", 1'b0);
            check("rst.flag", 8'(Flag5_PCRA_Flip), 8'd0);
            tick();
        end

        // data access for 3 cycles
        DataBusReq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk_bus("data", 1'b1, 2'b01, 1'b0);
            chk_fs("data.fs", 1'b0);
            tick();
        end
        DataBusReq = 1'b0;
        chk_bus("data.end", 1'b0, 2'b00, 1'b0);

        // plain flush: 2 cycles
        BranchTaken = 1'b1;
        tick();
        BranchTaken = 1'b0;
        chk_fs("fl.a1", 1'b1);
        tick();
        chk_fs("fl.a2", 1'b1);
        tick();
        chk_fs("fl.a3", 1'b0);

        // data access during flush stretches it to 3
        BranchTaken = 1'b1;
        tick();
        BranchTaken = 1'b0;
        DataBusReq = 1'b1;
        chk_fs("fl.b1", 1'b1);
        tick();
        DataBusReq = 1'b0;
        chk_fs("fl.b2", 1'b1);
        tick();
        chk_fs("fl.b3", 1'b1);
        tick();
        chk_fs("fl.b4", 1'b0);

        // second branch restarts the flush
        BranchTaken = 1'b1;
        tick();
        BranchTaken = 1'b0;
        chk_fs("fl.c1", 1'b1);
        tick();
        BranchTaken = 1'b1;
        chk_fs("fl.c2", 1'b1);
        tick();
        BranchTaken = 1'b0;
        chk_fs("fl.c3", 1'b1);
        tick();
        chk_fs("fl.c4", 1'b1);
        tick();
        chk_fs("fl.c5", 1'b0);

        // DMA request while a data access is in flight
        DmaReq = 1'b1;
        DataBusReq = 1'b1;
        chk_bus("dma.w0", 1'b1, 2'b01, 1'b0);
        tick();
        chk_bus("dma.w1", 1'b1, 2'b01, 1'b0);
        tick();
        DataBusReq = 1'b0;
        chk_bus("dma.run", 1'b0, 2'b00, 1'b0);
        tick();
        chk_bus("dma.sync", 1'b1, 2'b11, 1'b0);
        tick();
        DataBusReq = 1'b1;
        chk_bus("dma.g0", 1'b1, 2'b10, 1'b1);
        tick();
        DataBusReq = 1'b0;
        DmaReq = 1'b0;
        chk_bus("dma.g1", 1'b1, 2'b10, 1'b1);
        tick();
        chk_bus("dma.rel", 1'b1, 2'b11, 1'b0);
        tick();
        chk_bus("dma.back", 1'b0, 2'b00, 1'b0);

        // two flips in RUN
        PcraFlipReq = 1'b1;
        tick();
        PcraFlipReq = 1'b0;
        check("flip1", 8'(Flag5_PCRA_Flip), 8'd1);
        PcraFlipReq = 1'b1;
        tick();
        PcraFlipReq = 1'b0;
        check("flip2", 8'(Flag5_PCRA_Flip), 8'd0);

        // held DMA: forced release after 4 grant cycles, then regrant
        DmaReq = 1'b1;
        tick();
        chk_bus("frc.sync", 1'b1, 2'b11, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk_bus("frc.grant", 1'b1, 2'b10, 1'b1);
            tick();
        end
        chk_bus("frc.rel", 1'b1, 2'b11, 1'b0);
        tick();
        chk_bus("frc.run", 1'b0, 2'b00, 1'b0);
        tick();
        chk_bus("frc.sync2", 1'b1, 2'b11, 1'b0);
        tick();
        chk_bus("frc.grant2", 1'b1, 2'b10, 1'b1);

        // flip during grant, then reset mid-grant
        PcraFlipReq = 1'b1;
        tick();
        PcraFlipReq = 1'b0;
        check("flip3", 8'(Flag5_PCRA_Flip), 8'd1);
        chk_bus("flip3.grant", 1'b1, 2'b10, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_bus("mrst", 1'b0, 2'b00, 1'b0);
        check("mrst.flag", 8'(Flag5_PCRA_Flip), 8'd0);
        DmaReq = 1'b0;

        // simultaneous branch and flip
        BranchTaken = 1'b1;
        PcraFlipReq = 1'b1;
        tick();
        BranchTaken = 1'b0;
        PcraFlipReq = 1'b0;
        chk_fs("both.fs", 1'b1);
        check("both.flag", 8'(Flag5_PCRA_Flip), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
